mc_control: RTL and testbench

Multi-cycle main controller for the MIPS CPU. It sequences the shared datapath (PC, IR, register file, ALU, data memory) through FETCH/DECODE/EXE/MEM/WB states, one instruction at a time. It drives per-state control strobes and the datapath select codes. It also handshakes with a variable-latency data memory and counts retired instructions.

---
 rtl/mc_control.sv | 250 +++++++++++++++++++++++++
 tb/tb_mc_control.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main controller sequencing FETCH/DECODE/EXE/MEM/WB.
// Define MC_BGEZAL_EN to decode bgezal (op 000001, rt 10001); otherwise that opcode is illegal.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [4:0]       rt,
  input  logic             zero,
  input  logic             gez,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             dmem_req,
  output logic [1:0]       RegDst,
  output logic             ALUSrc,
  output logic [1:0]       MemtoReg,
  output logic [2:0]       ALUOp,
  output logic [1:0]       EXTOp,
  output logic [1:0]       NPCOp,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXE    = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100
  } state_t;

  typedef enum logic [3:0] {
    I_ILL, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW,
    I_BEQ, I_BNE, I_J, I_JAL, I_BGEZAL
  } instr_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  instr_t           instr;
  logic [CNT_W-1:0] cnt_reg;
  logic             bgezal_hit;
  logic             gez_taken;

`ifdef MC_BGEZAL_EN
  assign bgezal_hit = (op == 6'b000001) && (rt == 5'b10001);
  assign gez_taken  = gez;
`else
  logic unused_bgezal;
  assign unused_bgezal = ^{rt, gez};
  assign bgezal_hit    = 1'b0;
  assign gez_taken     = 1'b0;
`endif

  // op/funct are only meaningful from DECODE onward; FETCH ignores the decode.
  always_comb begin
    instr = I_ILL;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          default:   instr = I_ILL;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b001111: instr = I_LUI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b000101: instr = I_BNE;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      6'b000001: instr = bgezal_hit ? I_BGEZAL : I_ILL;
      default:   instr = I_ILL;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    dmem_req   = 1'b0;
    RegDst     = 2'b00;
    ALUSrc     = 1'b0;
    MemtoReg   = 2'b00;
    ALUOp      = 3'b000;
    EXTOp      = 2'b00;
    NPCOp      = 2'b00;
    illegal    = 1'b0;
    instr_done = 1'b0;

    case (state_reg)
      S_FETCH: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        case (instr)
          I_J: begin
            PCWrite    = 1'b1;
            NPCOp      = 2'b10;
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
          I_JR: begin
            PCWrite    = 1'b1;
            NPCOp      = 2'b11;
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
          I_JAL: begin
            PCWrite    = 1'b1;
            NPCOp      = 2'b10;
            state_next = S_WB;
          end
          I_ILL: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_EXE;
        endcase
      end

      S_EXE: begin
        case (instr)
          I_ADDU: state_next = S_WB;
          I_SUBU: begin
            ALUOp      = 3'b001;
            state_next = S_WB;
          end
          I_ORI: begin
            ALUOp      = 3'b010;
            ALUSrc     = 1'b1;
            state_next = S_WB;
          end
          I_LUI: begin
            ALUOp      = 3'b011;
            ALUSrc     = 1'b1;
            EXTOp      = 2'b10;
            state_next = S_WB;
          end
          I_LW, I_SW: begin
            ALUSrc     = 1'b1;
            EXTOp      = 2'b01;
            state_next = S_MEM;
          end
          // Branch target uses the sign-extended offset; the ALU subtract yields zero.
          I_BEQ, I_BNE: begin
            ALUOp      = 3'b001;
            EXTOp      = 2'b01;
            NPCOp      = 2'b01;
            PCWrite    = (instr == I_BEQ) ? zero : !zero;
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
          I_BGEZAL: begin
            EXTOp = 2'b01;
            NPCOp = 2'b01;
            if (gez_taken) begin
              PCWrite    = 1'b1;
              state_next = S_WB;
            end else begin
              instr_done = 1'b1;
              state_next = S_FETCH;
            end
          end
          default: state_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        ALUSrc   = 1'b1;
        EXTOp    = 2'b01;
        MemWrite = (instr == I_SW);
        if (dmem_ready) begin
          if (instr == I_SW) begin
            instr_done = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end

      S_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
        case (instr)
          I_ADDU, I_SUBU: RegDst = 2'b01;
          I_LW:           MemtoReg = 2'b01;
          I_JAL, I_BGEZAL: begin
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
          default: RegDst = 2'b00;
        endcase
      end

      default: state_next = S_FETCH;
    endcase

    // Reset masks every output combinationally so an in-flight access drops at once.
    if (!reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      dmem_req   = 1'b0;
      RegDst     = 2'b00;
      ALUSrc     = 1'b0;
      MemtoReg   = 2'b00;
      ALUOp      = 3'b000;
      EXTOp      = 2'b00;
      NPCOp      = 2'b00;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (instr_done) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign state     = state_reg;
  assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: expected per-instruction results are queued on issue
// and compared once the instruction retires or traps.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       zero;
  logic       gez;
  logic       dmem_ready;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, dmem_req;
  logic [1:0] RegDst;
  logic       ALUSrc;
  logic [1:0] MemtoReg;
  logic [2:0] ALUOp;
  logic [1:0] EXTOp;
  logic [1:0] NPCOp;
  logic [2:0] state;
  logic       illegal;
  logic       instr_done;
  logic [3:0] instr_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [3:0] exp_cnt = 4'd0;

  typedef struct {
    int          cycles;
    logic [31:0] trace;
    int          ill;
    int          done;
    int          rw;
    logic [1:0]  regdst;
    logic [1:0]  memtoreg;
    int          req;
    int          mw;
    int          br;
    logic [1:0]  jmp;
    int          alu;
    logic [4:0]  mem_sel;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  mc_control #(.CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .rt         (rt),
    .zero       (zero),
    .gez        (gez),
    .dmem_ready (dmem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .dmem_req   (dmem_req),
    .RegDst     (RegDst),
    .ALUSrc     (ALUSrc),
    .MemtoReg   (MemtoReg),
    .ALUOp      (ALUOp),
    .EXTOp      (EXTOp),
    .NPCOp      (NPCOp),
    .state      (state),
    .illegal    (illegal),
    .instr_done (instr_done),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from the start of its FETCH cycle until retire/trap.
  task automatic run(input string tag, input int nwait);
    int          n = 0;
    int          mem_n = 0;
    bit          finished = 1'b0;
    logic [31:0] trace = 32'd1;
    int          ill = 0, done = 0, rw = 0, req = 0, mw = 0, br = 0, irw = 0, fpc = 0;
    logic [1:0]  regdst = 2'b00, memtoreg = 2'b00, jmp = 2'b00;
    int          alu = -1;
    logic [4:0]  mem_sel = 5'd0;
    exp_t        e;
    while (!finished && n < 40) begin
      if (state == 3'd3) begin
        dmem_ready = (mem_n == nwait);
        mem_n++;
      end else begin
        dmem_ready = 1'b1;
      end
      @(negedge clk);
      n++;
      trace = (trace << 3) | {29'd0, state};
      if (RegWrite) begin
        rw++;
        regdst   = RegDst;
        memtoreg = MemtoReg;
      end
      if (dmem_req) req++;
      if (MemWrite) mw++;
      if (IRWrite) irw++;
      if (PCWrite && NPCOp == 2'b00) fpc++;
      if (PCWrite && NPCOp == 2'b01) br++;
      if (state == 3'd1 && PCWrite) jmp = NPCOp;
      if (state == 3'd2) alu = {26'd0, ALUOp, ALUSrc, EXTOp};
      if (state == 3'd3) mem_sel = {ALUOp, EXTOp};
      if (illegal) ill++;
      if (instr_done) done++;
      finished = instr_done || illegal;
      @(posedge clk);
      #1;
    end
    check({tag, ".timeout"}, {31'd0, finished}, 32'd1);
    check({tag, ".sb_nonempty"}, (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ".cycles"}, n, e.cycles);
      check({tag, ".trace"}, trace, e.trace);
      check({tag, ".illegal"}, ill, e.ill);
      check({tag, ".done"}, done, e.done);
      check({tag, ".regwrite"}, rw, e.rw);
      check({tag, ".regdst"}, {30'd0, regdst}, {30'd0, e.regdst});
      check({tag, ".memtoreg"}, {30'd0, memtoreg}, {30'd0, e.memtoreg});
      check({tag, ".dmem_req"}, req, e.req);
      check({tag, ".memwrite"}, mw, e.mw);
      check({tag, ".branch"}, br, e.br);
      check({tag, ".jump_npc"}, {30'd0, jmp}, {30'd0, e.jmp});
      check({tag, ".irwrite"}, irw, 1);
      check({tag, ".fetch_pc"}, fpc, 1);
      if (e.alu >= 0) check({tag, ".alu"}, alu, e.alu);
      check({tag, ".mem_sel"}, {27'd0, mem_sel}, {27'd0, e.mem_sel});
      check({tag, ".cnt"}, {28'd0, instr_cnt}, {28'd0, e.cnt});
      check({tag, ".back_fetch"}, {29'd0, state}, 32'd0);
    end
    $display("[TB] %s: %0d cycles, illegal=%0d, instr_cnt=%0d", tag, n, ill, instr_cnt);
  endtask

  task automatic issue(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] r, input logic z, input logic g, input int nwait,
                       input int cycles, input logic [31:0] trace, input bit ill, input int rw,
                       input logic [1:0] rd, input logic [1:0] mr, input int br,
                       input logic [1:0] jmp, input int alu);
    exp_t e;
    bit   is_mem;
    is_mem     = (o == 6'h23) || (o == 6'h2b);
    e.cycles   = cycles;
    e.trace    = trace;
    e.ill      = ill ? 1 : 0;
    e.done     = ill ? 0 : 1;
    e.rw       = rw;
    e.regdst   = rd;
    e.memtoreg = mr;
    e.req      = is_mem ? nwait + 1 : 0;
    e.mw       = (o == 6'h2b) ? nwait + 1 : 0;
    e.br       = br;
    e.jmp      = jmp;
    e.alu      = alu;
    e.mem_sel  = is_mem ? 5'b00001 : 5'b00000;
    if (!ill) exp_cnt = exp_cnt + 4'd1;
    e.cnt      = exp_cnt;
    exp_q.push_back(e);
    op = o; funct = f; rt = r; zero = z; gez = g;
    run(tag, nwait);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    op = 6'd0; funct = 6'd0; rt = 5'd0; zero = 1'b0; gez = 1'b0; dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.state", {29'd0, state}, 32'd0);
    check("reset.cnt", {28'd0, instr_cnt}, 32'd0);
    check("reset.strobes", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, dmem_req}, 32'd0);
    check("reset.pulses", {30'd0, illegal, instr_done}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    $display("[TB] reset released");

    //     tag          op     funct  rt     z     g     wt cyc trace         ill rw rd     mr     br jmp    alu
    issue("addu",      6'h00, 6'h21, 5'h00, 1'b0, 1'b0, 0, 4, 'o10124,     0,  1, 2'b01, 2'b00, 0, 2'b00, 0);
    issue("subu",      6'h00, 6'h23, 5'h00, 1'b0, 1'b0, 0, 4, 'o10124,     0,  1, 2'b01, 2'b00, 0, 2'b00, 8);
    issue("ori",       6'h0d, 6'h00, 5'h00, 1'b0, 1'b0, 0, 4, 'o10124,     0,  1, 2'b00, 2'b00, 0, 2'b00, 20);
    issue("lui",       6'h0f, 6'h00, 5'h00, 1'b0, 1'b0, 0, 4, 'o10124,     0,  1, 2'b00, 2'b00, 0, 2'b00, 30);
    issue("lw_wait3",  6'h23, 6'h00, 5'h00, 1'b0, 1'b0, 3, 8, 'o101233334, 0,  1, 2'b00, 2'b01, 0, 2'b00, 5);
    issue("lw_wait0",  6'h23, 6'h00, 5'h00, 1'b0, 1'b0, 0, 5, 'o101234,    0,  1, 2'b00, 2'b01, 0, 2'b00, 5);
    issue("sw_wait2",  6'h2b, 6'h00, 5'h00, 1'b0, 1'b0, 2, 6, 'o1012333,   0,  0, 2'b00, 2'b00, 0, 2'b00, 5);
    issue("beq_taken", 6'h04, 6'h00, 5'h00, 1'b1, 1'b0, 0, 3, 'o1012,      0,  0, 2'b00, 2'b00, 1, 2'b00, -1);
    issue("beq_not",   6'h04, 6'h00, 5'h00, 1'b0, 1'b0, 0, 3, 'o1012,      0,  0, 2'b00, 2'b00, 0, 2'b00, -1);
    issue("bne_taken", 6'h05, 6'h00, 5'h00, 1'b0, 1'b0, 0, 3, 'o1012,      0,  0, 2'b00, 2'b00, 1, 2'b00, -1);
    issue("bne_not",   6'h05, 6'h00, 5'h00, 1'b1, 1'b0, 0, 3, 'o1012,      0,  0, 2'b00, 2'b00, 0, 2'b00, -1);
    issue("j",         6'h02, 6'h00, 5'h00, 1'b0, 1'b0, 0, 2, 'o101,       0,  0, 2'b00, 2'b00, 0, 2'b10, -1);
    issue("jr",        6'h00, 6'h08, 5'h00, 1'b0, 1'b0, 0, 2, 'o101,       0,  0, 2'b00, 2'b00, 0, 2'b11, -1);
    issue("jal",       6'h03, 6'h00, 5'h00, 1'b0, 1'b0, 0, 3, 'o1014,      0,  1, 2'b10, 2'b10, 0, 2'b10, -1);
    issue("ill_op",    6'h3f, 6'h00, 5'h00, 1'b0, 1'b0, 0, 2, 'o101,       1,  0, 2'b00, 2'b00, 0, 2'b00, -1);
    issue("ill_funct", 6'h00, 6'h00, 5'h00, 1'b0, 1'b0, 0, 2, 'o101,       1,  0, 2'b00, 2'b00, 0, 2'b00, -1);
    issue("regimm_rt0",6'h01, 6'h00, 5'h00, 1'b0, 1'b1, 0, 2, 'o101,       1,  0, 2'b00, 2'b00, 0, 2'b00, -1);
`ifdef MC_BGEZAL_EN
    issue("bgezal_not",6'h01, 6'h00, 5'h11, 1'b0, 1'b0, 0, 3, 'o1012,      0,  0, 2'b00, 2'b00, 0, 2'b00, -1);
    issue("bgezal_tk", 6'h01, 6'h00, 5'h11, 1'b0, 1'b1, 0, 4, 'o10124,     0,  1, 2'b10, 2'b10, 1, 2'b00, -1);
`else
    issue("bgezal_not",6'h01, 6'h00, 5'h11, 1'b0, 1'b0, 0, 2, 'o101,       1,  0, 2'b00, 2'b00, 0, 2'b00, -1);
    issue("bgezal_tk", 6'h01, 6'h00, 5'h11, 1'b0, 1'b1, 0, 2, 'o101,       1,  0, 2'b00, 2'b00, 0, 2'b00, -1);
`endif

    // Asynchronous reset in the middle of a stalled sw access.
    op = 6'h2b; funct = 6'h00; rt = 5'h00; dmem_ready = 1'b0;
    for (int k = 0; k < 10 && state != 3'd3; k++) begin
      @(posedge clk);
      #1;
    end
    check("rst_mem.reached", {29'd0, state}, 32'd3);
    @(negedge clk);
    check("rst_mem.req_before", {31'd0, dmem_req}, 32'd1);
    check("rst_mem.mw_before", {31'd0, MemWrite}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mem.req_after", {31'd0, dmem_req}, 32'd0);
    check("rst_mem.mw_after", {31'd0, MemWrite}, 32'd0);
    check("rst_mem.state", {29'd0, state}, 32'd0);
    check("rst_mem.cnt", {28'd0, instr_cnt}, 32'd0);
    check("rst_mem.strobes", {27'd0, PCWrite, IRWrite, RegWrite, illegal, instr_done}, 32'd0);
    exp_cnt = 4'd0;
    @(posedge clk);
    #1 reset = 1'b1;
    $display("[TB] reset asserted during sw MEM wait and released");

    // Counter wrap at CNT_W=4: 15 retires, a non-counted trap, then the 16th retire.
    for (int i = 0; i < 15; i++) begin
      issue("wrap_j",  6'h02, 6'h00, 5'h00, 1'b0, 1'b0, 0, 2, 'o101,       0,  0, 2'b00, 2'b00, 0, 2'b10, -1);
    end
    issue("wrap_ill",  6'h3f, 6'h00, 5'h00, 1'b0, 1'b0, 0, 2, 'o101,       1,  0, 2'b00, 2'b00, 0, 2'b00, -1);
    issue("wrap_last", 6'h02, 6'h00, 5'h00, 1'b0, 1'b0, 0, 2, 'o101,       0,  0, 2'b00, 2'b00, 0, 2'b10, -1);
    check("wrap.zero", {28'd0, instr_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
